// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_pkg: shared sprite geometry, widths and pixel types for the sprite ROM arbiter.
package sprite_pkg;
    localparam int SPR_W  = 40;
    localparam int SPR_H  = 60;
    localparam int DATA_W = 5;
    localparam int ADDR_W = 19;
    localparam logic [DATA_W-1:0] TRANSPARENT = '0;
    typedef logic [5:0]        coord_t;
    typedef logic [DATA_W-1:0] pix_t;
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: requester, ROM and response signals of the sprite ROM arbiter.
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = sprite_pkg::ADDR_W,
    parameter int DATA_W = sprite_pkg::DATA_W
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ*6-1:0] req_x;
    logic [N_REQ*6-1:0] req_y;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_data;
    logic               rsp_valid;
    logic [2:0]         rsp_id;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_oob;
    modport master (output req, req_x, req_y, rom_data,
                    input  gnt, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_oob);
    modport slave  (input  req, req_x, req_y, rom_data,
                    output gnt, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_oob);
endinterface

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with combinational one-hot grant and binary index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt,
    output logic [IW-1:0] o_idx
);
    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_idx;

    // scan downward so the requester closest to ptr is assigned last and wins
    always_comb begin
        logic [IW-1:0] j;
        w_gnt = '0;
        w_idx = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(r_ptr) + k) % N);
            if (i_req[j]) begin
                w_gnt    = '0;
                w_gnt[j] = 1'b1;
                w_idx    = j;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (|w_gnt)
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
    end

    assign o_gnt = rst_n ? w_gnt : '0;
    assign o_idx = w_idx;
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one sprite ROM among N_REQ requesters with tagged two-stage responses.
module sprite_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int SPR_W  = sprite_pkg::SPR_W,
    parameter int SPR_H  = sprite_pkg::SPR_H,
    parameter int ADDR_W = sprite_pkg::ADDR_W,
    parameter int DATA_W = sprite_pkg::DATA_W
) (
    input logic                 Clk,
    input logic                 Reset_n,
    sprite_rom_arbiter_if.slave bus
);
    import sprite_pkg::*;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic              w_oob;
    coord_t            w_x;
    coord_t            w_y;
    logic [ADDR_W-1:0] w_addr;
    logic              r_v1, r_v2, r_oob1, r_oob2;
    logic [2:0]        r_id1, r_id2;
    logic [ADDR_W-1:0] r_addr;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk   (Clk),
        .rst_n (Reset_n),
        .i_req (bus.req),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_any = |w_gnt;
    assign w_x   = bus.req_x[6*w_idx +: 6];
    assign w_y   = bus.req_y[6*w_idx +: 6];
    // bounds are checked before the multiply so 63,63 can never alias a real pixel
    assign w_oob  = (int'(w_x) >= SPR_W) || (int'(w_y) >= SPR_H);
    assign w_addr = w_oob ? '0 : ADDR_W'(int'(w_y) * SPR_W + int'(w_x));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_v1   <= 1'b0;
            r_id1  <= '0;
            r_oob1 <= 1'b0;
            r_addr <= '0;
            r_v2   <= 1'b0;
            r_id2  <= '0;
            r_oob2 <= 1'b0;
        end else begin
            r_v1   <= w_any;
            r_id1  <= 3'(w_idx);
            r_oob1 <= w_any & w_oob;
            if (w_any)
                r_addr <= w_addr;
            r_v2   <= r_v1;
            r_id2  <= r_id1;
            r_oob2 <= r_oob1;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.rom_addr  = r_addr;
    assign bus.rsp_valid = r_v2;
    assign bus.rsp_id    = r_id2;
    assign bus.rsp_oob   = r_oob2;
    assign bus.rsp_data  = (r_v2 && !r_oob2) ? bus.rom_data : DATA_W'(TRANSPARENT);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed and randomized checks of the sprite ROM arbiter against a queue-based model.
module tb_sprite_rom_arbiter;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(19), .DATA_W(5)) bus ();

    sprite_rom_arbiter #(.N_REQ(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    logic [4:0] mem [0:2399];
    always @(posedge Clk) bus.rom_data <= (bus.rom_addr < 19'd2400) ? mem[bus.rom_addr] : 5'd0;

    typedef struct {int due; int id; int data; int oob;} rsp_t;
    rsp_t rq[$];
    int   m_ptr, m_addr, cyc, n_chk, n_fail;
    bit   m_anew;

    function automatic int pick();
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (bus.req[j] === 1'b1) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(int g);
        return (g < 0) ? 4'd0 : 4'(1 << g);
    endfunction

    function automatic bit exp_v();
        return rq.size() > 0 && rq[0].due == cyc;
    endfunction

    task automatic drive(int i, bit on, int x, int y);
        bus.req[i] = on;
        bus.req_x[6*i +: 6] = 6'(x);
        bus.req_y[6*i +: 6] = 6'(y);
    endtask

    task automatic adv(output int g);
        int x, y, a;
        bit oob;
        g = pick();
        m_anew = (g >= 0);
        if (g >= 0) begin
            x   = int'(bus.req_x[6*g +: 6]);
            y   = int'(bus.req_y[6*g +: 6]);
            oob = (x >= 40) || (y >= 60);
            a   = oob ? 0 : y * 40 + x;
            m_addr = a;
            rq.push_back('{cyc + 2, g, oob ? 0 : int'(mem[a]), int'(oob)});
            m_ptr = (g + 1) % 4;
        end
        @(posedge Clk);
        cyc++;
        while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        bus.req = '0;
        rq.delete();
        m_ptr = 0;
        m_anew = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req = 4'hF;
        bus.req_x = '0;
        bus.req_y = '0;
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'd0) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
        n_chk++; if (bus.rom_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.rom_addr); end
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.rsp_valid); end
        n_chk++; if (bus.rsp_id !== 3'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", bus.rsp_id); end
        n_chk++; if (bus.rsp_data !== 5'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", bus.rsp_data); end
        n_chk++; if (bus.rsp_oob !== 1'b0) begin n_fail++; $display("FAIL reset_oob got %b want 0", bus.rsp_oob); end
        @(posedge Clk);
        #1;
        bus.req = '0;
        Reset_n = 1'b1;
    endtask

    task automatic test_single();
        int g;
        drive(2, 1, 3, 1);
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got %b want 0100", bus.gnt); end
        adv(g);
        drive(2, 0, 0, 0);
        @(negedge Clk);
        n_chk++; if (bus.rom_addr !== 19'd43) begin n_fail++; $display("FAIL single_addr got %0d want 43", bus.rom_addr); end
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", bus.rsp_valid); end
        adv(g);
        @(negedge Clk);
        n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus.rsp_valid); end
        n_chk++; if (bus.rsp_id !== 3'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", bus.rsp_id); end
        n_chk++; if (bus.rsp_data !== mem[43]) begin n_fail++; $display("FAIL single_data got %0d want %0d", bus.rsp_data, mem[43]); end
        n_chk++; if (bus.rsp_oob !== 1'b0) begin n_fail++; $display("FAIL single_oob got %b want 0", bus.rsp_oob); end
        adv(g);
    endtask

    task automatic test_wrap();
        int g;
        drive(3, 1, 5, 5);
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_gnt3 got %b want 1000", bus.gnt); end
        adv(g);
        drive(3, 0, 0, 0);
        drive(0, 1, 1, 1);
        drive(2, 1, 2, 2);
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt0 got %b want 0001", bus.gnt); end
        adv(g);
        drive(0, 0, 0, 0);
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_gnt2 got %b want 0100", bus.gnt); end
        adv(g);
        drive(2, 0, 0, 0);
        repeat (2) adv(g);
    endtask

    task automatic test_contention();
        int g;
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 0, i * 7, i * 11);
        for (int k = 0; k < 10; k++) begin
            bus.req = (k < 8) ? 4'hF : 4'h0;
            @(negedge Clk);
            if (k < 8) begin
                n_chk++; if (bus.gnt !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rot_gnt[%0d] got %b want %b", k, bus.gnt, 4'(1 << (k % 4))); end
            end
            if (k >= 2) begin
                n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 3'((k - 2) % 4)) begin n_fail++; $display("FAIL rot_rsp[%0d] got v=%b id=%0d want v=1 id=%0d", k, bus.rsp_valid, bus.rsp_id, (k - 2) % 4); end
                n_chk++; if (int'(bus.rsp_data) != rq[0].data) begin n_fail++; $display("FAIL rot_data[%0d] got %0d want %0d", k, bus.rsp_data, rq[0].data); end
            end
            adv(g);
        end
    endtask

    task automatic test_bounds();
        int g;
        int xs[4] = '{39, 40, 63, 0};
        int ys[4] = '{59, 0, 63, 60};
        int ea[4] = '{2399, 0, 0, 0};
        int eo[4] = '{0, 1, 1, 1};
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(0, 1, xs[k], ys[k]);
            else drive(0, 0, 0, 0);
            @(negedge Clk);
            if (k < 4) begin
                n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL bnd_gnt[%0d] got %b want 0001", k, bus.gnt); end
            end
            if (k >= 1 && k <= 4) begin
                n_chk++; if (int'(bus.rom_addr) != ea[k-1]) begin n_fail++; $display("FAIL bnd_addr[%0d] got %0d want %0d", k, bus.rom_addr, ea[k-1]); end
            end
            if (k >= 2) begin
                n_chk++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_oob) != eo[k-2]) begin n_fail++; $display("FAIL bnd_oob[%0d] got v=%b oob=%b want v=1 oob=%0d", k, bus.rsp_valid, bus.rsp_oob, eo[k-2]); end
                n_chk++; if (bus.rsp_data !== ((eo[k-2] != 0) ? 5'd0 : mem[2399])) begin n_fail++; $display("FAIL bnd_data[%0d] got %0d want %0d", k, bus.rsp_data, (eo[k-2] != 0) ? 5'd0 : mem[2399]); end
            end
            adv(g);
        end
    endtask

    task automatic test_idle();
        int g;
        drive(1, 1, 7, 7);
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL idle_first got %b want 0010", bus.gnt); end
        adv(g);
        drive(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            n_chk++; if (bus.gnt !== 4'd0) begin n_fail++; $display("FAIL idle_gnt[%0d] got %b want 0000", k, bus.gnt); end
            n_chk++; if (bus.rsp_valid !== (k == 1)) begin n_fail++; $display("FAIL idle_valid[%0d] got %b want %b", k, bus.rsp_valid, k == 1); end
            adv(g);
        end
        bus.req = 4'hF;
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL idle_resume got %b want 0100", bus.gnt); end
        adv(g);
        bus.req = '0;
        repeat (2) adv(g);
    endtask

    task automatic test_reset_midflight();
        int g;
        drive(0, 1, 2, 2);
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_gnt got %b want 0001", bus.gnt); end
        adv(g);
        Reset_n = 1'b0;
        rq.delete();
        m_ptr = 0;
        m_anew = 1'b0;
        bus.req = 4'b0110;
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'd0 || bus.rom_addr !== 19'd0) begin n_fail++; $display("FAIL mid_inreset got gnt=%b addr=%0d want 0000 0", bus.gnt, bus.rom_addr); end
        @(posedge Clk);
        #1;
        @(negedge Clk);
        n_chk++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 5'd0 || bus.rsp_id !== 3'd0 || bus.rsp_oob !== 1'b0) begin n_fail++; $display("FAIL mid_rsp got v=%b d=%0d id=%0d oob=%b want all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_oob); end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        bus.req = 4'hF;
        @(negedge Clk);
        n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_release got %b want 0001", bus.gnt); end
        adv(g);
        bus.req = '0;
        repeat (2) adv(g);
    endtask

    task automatic test_random();
        int g, eg, x, y;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req[i] !== 1'b1 && $urandom_range(0, 2) == 0) begin
                    x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 39));
                    y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 59));
                    drive(i, 1, x, y);
                end
            end
            @(negedge Clk);
            eg = pick();
            n_chk++; if (bus.gnt !== onehot(eg)) begin n_fail++; $display("FAIL rnd_gnt[%0d] got %b want %b", c, bus.gnt, onehot(eg)); end
            if (m_anew) begin
                n_chk++; if (int'(bus.rom_addr) != m_addr) begin n_fail++; $display("FAIL rnd_addr[%0d] got %0d want %0d", c, bus.rom_addr, m_addr); end
            end
            n_chk++; if (bus.rsp_valid !== exp_v()) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", c, bus.rsp_valid, exp_v()); end
            if (exp_v()) begin
                n_chk++; if (int'(bus.rsp_id) != rq[0].id || int'(bus.rsp_data) != rq[0].data || int'(bus.rsp_oob) != rq[0].oob) begin n_fail++; $display("FAIL rnd_rsp[%0d] got id=%0d d=%0d oob=%b want id=%0d d=%0d oob=%0d", c, bus.rsp_id, bus.rsp_data, bus.rsp_oob, rq[0].id, rq[0].data, rq[0].oob); end
            end
            adv(g);
            if (g >= 0) begin
                if ($urandom_range(0, 1) == 1) drive(g, 1, int'($urandom_range(0, 39)), int'($urandom_range(0, 63)));
                else drive(g, 0, 0, 0);
            end
        end
    endtask

    initial begin
        int g;
        for (int a = 0; a < 2400; a++) mem[a] = 5'($urandom_range(0, 31));
        mem[0] = 5'd17;
        mem[43] = 5'd9;
        mem[2399] = 5'd22;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        m_ptr = 0;
        m_addr = 0;
        m_anew = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_bounds();
        test_idle();
        test_reset_midflight();
        test_random();
        bus.req = '0;
        repeat (2) adv(g);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
